// File: rtl/re_ack_pkg.sv
`default_nettype none
// ============================================================================
// re_ack_pkg : shared types and defaults for the re_ack_sequencer block
// Revision   : 1.0
// ============================================================================
package re_ack_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SAMPLE   = 3'd1,
      HOLD     = 3'd2,
      ACK      = 3'd3,
      WAIT_REL = 3'd4
   } state_t;

   localparam logic GNT_FWD = 1'b0;
   localparam logic GNT_RE  = 1'b1;

   localparam int DEF_GO_CYCLES = 4;
   localparam int DEF_CNT_W     = 3;
   localparam int DEF_TIMEOUT   = 16;
   localparam int DEF_TO_W      = 5;

endpackage
`default_nettype wire

// File: rtl/re_ack_sequencer_if.sv
`default_nettype none
// ============================================================================
// re_ack_sequencer_if : two 4-phase requesters plus shared latch-stage controls
// Revision            : 1.0
// ============================================================================
interface re_ack_sequencer_if;

   logic rreq;
   logic rack;
   logic rereq;
   logic reack;
   logic sample;
   logic goml;
   logic gnt_re;
   logic err;

   modport master (
      output rreq, rereq,
      input  rack, reack, sample, goml, gnt_re, err
   );

   modport slave (
      input  rreq, rereq,
      output rack, reack, sample, goml, gnt_re, err
   );

endinterface
`default_nettype wire

// File: rtl/re_ack_hold_cnt.sv
`default_nettype none
// ============================================================================
// re_ack_hold_cnt : loadable saturating down-counter with zero flag
// Revision        : 1.0
// ============================================================================
module re_ack_hold_cnt #(
   parameter int CNT_W = 3
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             load_i,
   input  wire logic [CNT_W-1:0] val_i,
   input  wire logic             dec_i,
   output logic                  zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/re_ack_sequencer.sv
`default_nettype none
// ============================================================================
// re_ack_sequencer : round-robin sequencer sharing one sample/master-latch stage
// Revision         : 1.0
// ============================================================================
module re_ack_sequencer
   import re_ack_pkg::*;
#(
   parameter int GO_CYCLES = DEF_GO_CYCLES,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int TO_W      = DEF_TO_W
) (
   input  wire logic         clk,
   input  wire logic         rst,
   re_ack_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(GO_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0]  TO_MAX    = '1;

   state_t          state_q, state_d;
   logic            rreq_q, rereq_q;
   logic            pend_f_q, pend_f_d, pend_r_q, pend_r_d;
   logic            gnt_re_q, gnt_re_d;
   logic            err_q, err_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            sample_q, goml_q, rack_q, reack_q;
   logic            elig_f, elig_r, grant_f, grant_r, greq;
   logic            hold_load, hold_dec, hold_zero;

   re_ack_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (hold_load),
      .val_i  (HOLD_INIT),
      .dec_i  (hold_dec),
      .zero_o (hold_zero)
   );

   always_comb begin
      state_d   = state_q;
      gnt_re_d  = gnt_re_q;
      to_cnt_d  = '0;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      grant_f   = 1'b0;
      grant_r   = 1'b0;
      // A request is eligible on a fresh rising edge or while still pending.
      elig_f    = bus.rreq  & (pend_f_q | ~rreq_q);
      elig_r    = bus.rereq & (pend_r_q | ~rereq_q);
      greq      = gnt_re_q ? bus.rereq : bus.rreq;
      case (state_q)
         IDLE: begin
            if (elig_f | elig_r) begin
               grant_r   = elig_r & (~elig_f | ~gnt_re_q);
               grant_f   = ~grant_r;
               gnt_re_d  = grant_r ? GNT_RE : GNT_FWD;
               hold_load = 1'b1;
               state_d   = SAMPLE;
            end
         end
         SAMPLE, HOLD: begin
            if (hold_zero) begin
               state_d = ACK;
            end else begin
               hold_dec = 1'b1;
               state_d  = HOLD;
            end
         end
         ACK: begin
            state_d  = WAIT_REL;
            to_cnt_d = TO_W'(1);
         end
         WAIT_REL: begin
            if (!greq) begin
               state_d = IDLE;
            end else begin
               to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      pend_f_d = elig_f & ~grant_f;
      pend_r_d = elig_r & ~grant_r;
      err_d    = err_q | ((state_d == WAIT_REL) && (to_cnt_d >= TO_LIMIT));
   end

   // Held requests are captured at reset so they need a fresh edge afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rreq_q   <= bus.rreq;
         rereq_q  <= bus.rereq;
         pend_f_q <= 1'b0;
         pend_r_q <= 1'b0;
         gnt_re_q <= 1'b1;
         err_q    <= 1'b0;
         to_cnt_q <= '0;
         sample_q <= 1'b0;
         goml_q   <= 1'b0;
         rack_q   <= 1'b0;
         reack_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rreq_q   <= bus.rreq;
         rereq_q  <= bus.rereq;
         pend_f_q <= pend_f_d;
         pend_r_q <= pend_r_d;
         gnt_re_q <= gnt_re_d;
         err_q    <= err_d;
         to_cnt_q <= to_cnt_d;
         sample_q <= (state_d == SAMPLE);
         goml_q   <= (state_d == SAMPLE) || (state_d == HOLD);
         rack_q   <= (state_d == WAIT_REL) && (gnt_re_d == GNT_FWD);
         reack_q  <= (state_d == WAIT_REL) && (gnt_re_d == GNT_RE);
      end
   end

   assign bus.sample = sample_q;
   assign bus.goml   = goml_q;
   assign bus.rack   = rack_q;
   assign bus.reack  = reack_q;
   assign bus.gnt_re = gnt_re_q;
   assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_re_ack_sequencer.sv
`default_nettype none
// ============================================================================
// tb_re_ack_sequencer : directed + random bench against a transaction-level model
// Revision            : 1.0
// ============================================================================
module tb_re_ack_sequencer;

   localparam int G   = 4;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;

   re_ack_sequencer_if bus ();

   re_ack_sequencer #(
      .GO_CYCLES (G),
      .CNT_W     (3),
      .TIMEOUT   (TMO),
      .TO_W      (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%b exp=%b", tag, got, exp);
   endtask

   // Model: t counts cycles since the grant edge (1 = sample cycle).
   bit m_busy, m_who, m_last, m_err, m_pf, m_pr, m_prevf, m_prevr;
   int m_t;

   function automatic logic [5:0] m_out();
      logic ack;
      ack = m_busy && (m_t >= G + 2);
      return {ack && !m_who, ack && m_who, m_busy && (m_t == 1),
              m_busy && (m_t <= G), m_last, m_err};
   endfunction

   task automatic model_step(input bit rs, input bit f, input bit r);
      bit wf, wr, gf, gr, held;
      if (rs) begin
         m_busy = 0; m_err = 0; m_last = 1; m_pf = 0; m_pr = 0; m_t = 0;
      end else begin
         wf = f && (m_pf || !m_prevf);
         wr = r && (m_pr || !m_prevr);
         gf = 0;
         gr = 0;
         if (m_busy) begin
            held = m_who ? r : f;
            if (m_t >= G + 2 && !held) m_busy = 0;
            else m_t++;
         end else if (wf || wr) begin
            if (wf && wr) gr = !m_last;
            else gr = wr;
            gf = !gr;
            m_busy = 1; m_who = gr; m_last = gr; m_t = 1;
         end
         m_pf = wf && !gf;
         m_pr = wr && !gr;
         if (m_busy && (m_t - (G + 1)) >= TMO) m_err = 1;
      end
      m_prevf = f;
      m_prevr = r;
   endtask

   logic [5:0] obs;  // {rack, reack, sample, goml, gnt_re, err}
   bit hold_mode = 0;

   task automatic cyc(input bit rs, input bit f, input bit r);
      @(negedge clk);
      obs = {bus.rack, bus.reack, bus.sample, bus.goml, bus.gnt_re, bus.err};
      chk("outs", {2'b00, obs}, {2'b00, m_out()});
      rst       = rs;
      bus.rreq  = f;
      bus.rereq = r;
      model_step(rs, f, r);
   endtask

   function automatic bit nxt(input bit cur, input bit ack);
      if (!cur) return ($urandom_range(0, 4) == 0);
      if (ack)  return hold_mode ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 2) != 0);
      return ($urandom_range(0, 29) != 0);
   endfunction

   initial begin
      int ns;
      logic ov;
      bit f, r, rs;
      logic [5:0] e;

      rst = 1'b1; bus.rreq = 1'b0; bus.rereq = 1'b0;
      model_step(1, 0, 0);

      // reset state
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
      chk("rst_state", {2'b00, obs}, 8'b0000_0010);

      // single forward transaction timing
      cyc(0, 1, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(0, 1, 0);
         chk("t2_seq", {5'd0, obs[5], obs[3], obs[2]},
             {5'd0, 1'(k >= 6), 1'(k == 1), 1'(k <= 4)});
      end
      cyc(0, 0, 0);
      chk("t2_held", {7'd0, obs[5]}, 8'd1);
      cyc(0, 0, 0);
      chk("t2_drop", {7'd0, obs[5]}, 8'd0);

      // simultaneous requests, round robin, pending served afterwards
      cyc(1, 0, 0); cyc(0, 0, 0);
      ns = 0; ov = 1'b0;
      cyc(0, 1, 1);
      for (int k = 1; k <= 27; k++) begin
         if (k <= 11)      cyc(0, 1, 1);
         else if (k <= 23) cyc(0, 0, 1);
         else              cyc(0, 0, 0);
         ns += int'(obs[3]);
         ov |= obs[5] & obs[4];
         if (k == 1) chk("t3_first_fwd", {7'd0, obs[1]}, 8'd0);
      end
      chk("t3_samples", 8'(ns), 8'd2);
      chk("t3_overlap", {7'd0, ov}, 8'd0);
      chk("t3_last_re", {7'd0, obs[1]}, 8'd1);

      // release timeout and sticky err
      cyc(0, 0, 1);
      for (int k = 1; k <= 25; k++) begin
         cyc(0, 0, 1);
         if (k == 6)  chk("t4_reack", {7'd0, obs[4]}, 8'd1);
         if (k == 20) chk("t4_err_early", {7'd0, obs[0]}, 8'd0);
         if (k == 21) chk("t4_err_set", {7'd0, obs[0]}, 8'd1);
      end
      for (int k = 0; k < 4; k++) cyc(0, 0, 0);
      chk("t4_sticky", {6'd0, obs[4], obs[0]}, 8'd1);
      cyc(1, 0, 0); cyc(0, 0, 0);
      chk("t4_clr", {7'd0, obs[0]}, 8'd0);

      // reset during HOLD, held request needs a fresh edge
      cyc(0, 1, 0); cyc(0, 1, 0);
      cyc(1, 1, 0);
      chk("t5_goml", {7'd0, obs[2]}, 8'd1);
      cyc(0, 1, 0);
      chk("t5_abort", {2'b00, obs}, 8'b0000_0010);
      ns = 0;
      for (int k = 0; k < 14; k++) begin
         cyc(0, 1, 0);
         ns += int'(obs[3]);
      end
      chk("t5_no_regrant", 8'(ns), 8'd0);
      cyc(0, 0, 0); cyc(0, 1, 0);
      ns = 0;
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 0);
         ns += int'(obs[3]);
      end
      chk("t5_regrant", 8'(ns), 8'd1);
      for (int k = 0; k < 12; k++) cyc(0, 1, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0);

      // randomized traffic
      f = 0; r = 0;
      for (int i = 0; i < 4000; i++) begin
         e = m_out();
         if ($urandom_range(0, 199) == 0) hold_mode = ~hold_mode;
         rs = ($urandom_range(0, 149) == 0);
         f  = nxt(f, e[5]);
         r  = nxt(r, e[4]);
         cyc(rs, f, r);
      end
      cyc(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
